adc_interface_mc: RTL

- Multi-channel successor to the single-channel ADC1175 front end.
- Generates one shared, programmable-divided ADC clock and captures N_CH parallel ADC buses on each ADC rising edge.
- Reduces each channel per window by one of four modes: decimate, average, max, min.
- Buffers packed results in a first-word-fall-through FIFO behind the simple interface (rdy/ack) consumed by the trigger/buffer path.

---
 rtl/adc_interface_mc_pkg.sv | 20 ++
 rtl/adc_interface_mc_if.sv | 15 +
 rtl/adc_interface_mc_sync_fifo_fwft.sv | 59 +++++
 rtl/adc_interface_mc.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/adc_interface_mc_pkg.sv
// Shared definitions for the multi-channel ADC front end:
// reduction mode encodings, default window limit and the window-length clamp.
package adc_interface_mc_pkg;

  typedef enum logic [1:0] {
    ADC_MODE_DECIM = 2'd0,
    ADC_MODE_AVG   = 2'd1,
    ADC_MODE_MAX   = 2'd2,
    ADC_MODE_MIN   = 2'd3
  } adc_mode_e;

  localparam int unsigned ADC_MAX_AVG_LOG_DEFAULT = 4;

  // Requested log2 window length, limited to the largest supported one.
  function automatic logic [2:0] adc_eff_log(input logic [2:0] log_req,
                                             input logic [2:0] log_max);
    return (log_req > log_max) ? log_max : log_req;
  endfunction

endpackage

// File: rtl/adc_interface_mc_if.sv
// Simple-interface result bus (rdy/ack) between the ADC front end and the
// trigger/buffer path.
//   SI_data : packed result at the FIFO head
//   SI_rdy  : result available
//   SI_ack  : consumer pops the head when SI_rdy=1
interface adc_interface_mc_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic [WIDTH-1:0] SI_data;
  logic             SI_rdy;
  logic             SI_ack;

  modport master (output SI_data, output SI_rdy, input SI_ack);
  modport slave  (input SI_data, input SI_rdy, output SI_ack);
endinterface

// File: rtl/adc_interface_mc_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: o_data always shows the head.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push/i_data : write request (ignored when full unless popping too)
//   i_pop      : pop request (ignored when empty)
//   o_data     : head entry, zero when empty
//   o_full, o_empty, o_level : occupancy status
module adc_interface_mc_sync_fifo_fwft #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == LW'(DEPTH));
  assign o_level   = r_count;
  assign o_data    = o_empty ? '0 : r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage needs no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + LW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - LW'(1);
    end
  end

endmodule

// File: rtl/adc_interface_mc.sv
// Multi-channel ADC front end: divided shared ADC clock, per-window reduction
// of N_CH parallel channels (decimate/average/max/min), results queued in a
// FWFT FIFO behind the rdy/ack simple interface.
//   clk_i, rst        : fpga clock, asynchronous active-low reset
//   ADC_data          : channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ADC_oe            : ADC output enable (active low, always enabled)
//   clk_o             : shared ADC clock
//   en                : acquisition enable
//   decimation_factor : clk_o half-period in clk_i cycles, 0 = bypass
//   mode, avg_log     : reduction mode and log2 window length
//   si                : result bus (master side)
//   overrun, clr_ovr  : sticky drop flag and its clear
//   fifo_level        : FIFO occupancy
module adc_interface_mc
  import adc_interface_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned N_CH          = 2,
  parameter int unsigned CLK_DIV_WIDTH = 32,
  parameter int unsigned MAX_AVG_LOG   = ADC_MAX_AVG_LOG_DEFAULT,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst,
  input  logic [N_CH*DATA_WIDTH-1:0]    ADC_data,
  output logic                          ADC_oe,
  output logic                          clk_o,
  input  logic                          en,
  input  logic [CLK_DIV_WIDTH-1:0]      decimation_factor,
  input  logic [1:0]                    mode,
  input  logic [2:0]                    avg_log,
  adc_interface_mc_if.master            si,
  output logic                          overrun,
  input  logic                          clr_ovr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned BUS_W = N_CH * DATA_WIDTH;
  localparam int unsigned ACC_W = DATA_WIDTH + MAX_AVG_LOG;
  localparam int unsigned WIN_W = MAX_AVG_LOG + 1;

  logic [CLK_DIV_WIDTH-1:0] r_counter;
  logic                     r_clk_div;
  logic                     w_bypass;
  logic                     w_wrap;
  logic                     w_strobe;

  logic [WIN_W-1:0] r_win_cnt;
  adc_mode_e        r_mode;
  adc_mode_e        w_cur_mode;
  logic [2:0]       r_log;
  logic [2:0]       w_cur_log;
  logic             w_first;
  logic             w_last;

  logic [BUS_W-1:0] w_result;
  logic [BUS_W-1:0] r_result;
  logic             r_push;
  logic             r_overrun;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_drop;

  assign ADC_oe = 1'b0;

  // Clock divider: counter runs 0..D-1, clk_o_div toggles on each wrap.
  assign w_bypass = (decimation_factor == '0);
  assign w_wrap   = (r_counter == decimation_factor - CLK_DIV_WIDTH'(1));
  assign clk_o    = w_bypass ? clk_i : r_clk_div;
  // Sample in the cycle that produces the clk_o rising edge.
  assign w_strobe = en && (w_bypass || (w_wrap && !r_clk_div));

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_counter <= '0;
      r_clk_div <= 1'b0;
    end else if (!en || w_bypass) begin
      r_counter <= '0;
      r_clk_div <= 1'b0;
    end else if (w_wrap) begin
      r_counter <= '0;
      r_clk_div <= ~r_clk_div;
    end else begin
      r_counter <= r_counter + CLK_DIV_WIDTH'(1);
    end
  end

  // Window control: mode/length are taken live on the first sample, latched after.
  assign w_first    = (r_win_cnt == '0);
  assign w_cur_mode = w_first ? adc_mode_e'(mode) : r_mode;
  assign w_cur_log  = w_first ? adc_eff_log(avg_log, 3'(MAX_AVG_LOG)) : r_log;
  assign w_last     = (w_cur_mode == ADC_MODE_DECIM) ||
                      (r_win_cnt == ((WIN_W'(1) << w_cur_log) - WIN_W'(1)));

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_win_cnt <= '0;
      r_mode    <= ADC_MODE_DECIM;
      r_log     <= '0;
    end else if (!en) begin
      r_win_cnt <= '0;
    end else if (w_strobe) begin
      if (w_first) begin
        r_mode <= w_cur_mode;
        r_log  <= w_cur_log;
      end
      r_win_cnt <= w_last ? '0 : r_win_cnt + WIN_W'(1);
    end
  end

  // Per-channel reducers.
  for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
    logic [DATA_WIDTH-1:0] w_sample;
    logic [DATA_WIDTH-1:0] w_res;
    logic [ACC_W-1:0]      r_acc;
    logic [ACC_W-1:0]      w_acc_next;

    assign w_sample = ADC_data[k*DATA_WIDTH +: DATA_WIDTH];

    // First sample of a window always loads the accumulator.
    always_comb begin
      w_acc_next = ACC_W'(w_sample);
      case (w_cur_mode)
        ADC_MODE_AVG: if (!w_first) w_acc_next = r_acc + ACC_W'(w_sample);
        ADC_MODE_MAX: if (!w_first && (r_acc > ACC_W'(w_sample))) w_acc_next = r_acc;
        ADC_MODE_MIN: if (!w_first && (r_acc < ACC_W'(w_sample))) w_acc_next = r_acc;
        default:      w_acc_next = ACC_W'(w_sample);
      endcase
    end

    assign w_res = (w_cur_mode == ADC_MODE_AVG) ? DATA_WIDTH'(w_acc_next >> w_cur_log)
                                                : w_acc_next[DATA_WIDTH-1:0];
    assign w_result[k*DATA_WIDTH +: DATA_WIDTH] = w_res;

    always_ff @(posedge clk_i or negedge rst) begin
      if (!rst)          r_acc <= '0;
      else if (!en)      r_acc <= '0;
      else if (w_strobe) r_acc <= w_acc_next;
    end
  end

  // Completed window result is registered, then pushed the following cycle.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_push   <= 1'b0;
      r_result <= '0;
    end else begin
      r_push <= w_strobe && w_last;
      if (w_strobe && w_last) r_result <= w_result;
    end
  end

  assign w_pop  = si.SI_ack && !w_empty;
  assign w_drop = r_push && w_full && !w_pop;

  // Sticky overrun; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst)         r_overrun <= 1'b0;
    else if (w_drop)  r_overrun <= 1'b1;
    else if (clr_ovr) r_overrun <= 1'b0;
  end

  assign overrun   = r_overrun;
  assign si.SI_rdy = !w_empty;

  adc_interface_mc_sync_fifo_fwft #(
    .WIDTH (BUS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst),
    .i_push  (r_push),
    .i_data  (r_result),
    .i_pop   (si.SI_ack),
    .o_data  (si.SI_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

endmodule
